inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BREAK_WORD, default 32'h0000_000D, meaning the instruction word that halts fetch.
REQ-003 SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous reset, active high.
REQ-006 ce  output  1  instruction memory read enable.
REQ-007 addr  output  32  byte address to instruction memory; always equals the internal PC.
REQ-008 data  input  32  combinational read word from memory; valid in the same cycle as ce/addr.
REQ-009 redirect_valid  input  1  branch/jump/exception redirect request.
REQ-010 redirect_pc  input  32  redirect target byte address.
REQ-011 out_valid  output  1  fetched instruction available to decode.
REQ-012 out_ready  input  1  decode accepts the instruction this cycle.
REQ-013 out_pc  output  32  address of the held instruction.
REQ-014 out_inst  output  32  held instruction word.
REQ-015 halted  output  1  a BREAK_WORD was fetched, or a fault occurred.
REQ-016 fault  output  1  a misaligned redirect target was received.
REQ-017 fetch_count  output  32  number of words captured since reset.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, HALT and FAULT.
REQ-019 IDLE SHALL last exactly one cycle after reset release, with ce=0, then enter RUN unconditionally.
REQ-020 Define accept = !out_valid || out_ready.
REQ-021 In RUN, ce SHALL be 1 iff accept && !redirect_valid; in all other states ce SHALL be 0.
REQ-022 On a clock edge in RUN with ce=1: out_inst<=data, out_pc<=pc, out_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
REQ-023 PC arithmetic SHALL be modulo 2^32; 0xFFFF_FFFC+4 wraps to 0 with no fault.
REQ-024 In RUN, accept=0 SHALL hold pc, out_pc, out_inst and out_valid unchanged (no drop, no duplicate).
REQ-025 In RUN, out_ready=1 with ce=0 SHALL clear out_valid at the next edge.
REQ-026 redirect_valid SHALL take priority over fetch and out_ready in RUN and HALT:
- if redirect_pc[1:0]==0: pc<=redirect_pc, out_valid<=0, state<=RUN, halted<=0;
- otherwise: out_valid<=0, fault<=1, halted<=1, state<=FAULT.
REQ-027 A captured word equal to BREAK_WORD SHALL be presented normally (out_valid=1), with pc left at the BREAK address (not advanced) and state<=HALT, halted<=1 at the same edge.
REQ-028 HALT SHALL keep out_valid until the handshake completes, then clear it; no further fetch occurs; a valid redirect resumes RUN per REQ-026.
REQ-029 FAULT SHALL be left only by reset; redirect_valid is ignored in FAULT.
REQ-030 redirect_valid in IDLE SHALL be ignored.
REQ-031 fetch_count SHALL wrap 0xFFFF_FFFF->0 and SHALL NOT count squashed or held cycles.
REQ-032 addr SHALL equal pc in every state, including when ce=0.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for a clock edge, set: pc=RESET_PC, state=IDLE, ce=0, out_valid=0, out_pc=0, out_inst=0, halted=0, fault=0, fetch_count=0.
REQ-034 rst asserted mid-fetch or mid-handshake SHALL discard the held instruction; the first post-reset capture occurs at the second rising edge after rst deasserts.

Verification
REQ-035 Sequential fetch: memory word i = 0x1000_0000+i, out_ready=1 -> out_pc 0x0,0x4,0x8 with out_inst 0x1000_0000,+1,+2 on consecutive cycles; fetch_count=3.
REQ-036 Backpressure: out_ready=0 for 3 cycles with out_valid=1 at pc 0x8 -> out_pc/out_inst held, ce=0, addr=0xC; on release 0x8 is consumed once, then 0xC.
REQ-037 Redirect: redirect_valid=1, redirect_pc=0x40 while out_valid=1 -> next cycle out_valid=0, addr=0x40; the next capture has out_pc=0x40.
REQ-038 Break: word 0x0000_000D at 0x34 -> out_inst=0x0000_000D, out_pc=0x34, halted=1, ce=0 thereafter, addr stays 0x34; redirect_pc=0x0 resumes RUN.
REQ-039 Misaligned redirect: redirect_pc=0x42 -> fault=1, halted=1, ce=0; a later redirect to 0x0 is ignored; rst clears fault.
REQ-040 Reset and wrap: rst pulse mid-stream -> all outputs zero asynchronously; separately, RESET_PC=0xFFFF_FFFC -> second out_pc=0x0, fault=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the PC through instruction memory, holds one fetched word
// for decode under a valid/ready handshake, and handles redirects, BREAK halts and faults.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] BREAK_WORD = 32'h0000_000D
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce,
  output logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] out_pc_nxt, out_inst_nxt, count_nxt;
  logic        out_valid_nxt, halted_nxt, fault_nxt;
  logic        accept, redirect_ok;

  assign accept      = !out_valid || out_ready;
  assign redirect_ok = (redirect_pc[1:0] == 2'b00);
  assign addr        = pc;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    pc_nxt        = pc;
    out_valid_nxt = out_valid;
    out_pc_nxt    = out_pc;
    out_inst_nxt  = out_inst;
    halted_nxt    = halted;
    fault_nxt     = fault;
    count_nxt     = fetch_count;
    ce            = 1'b0;

    unique case (state)
      IDLE: state_nxt = RUN;

      RUN, HALT: begin
        if (redirect_valid) begin
          // A redirect squashes whatever is held, even if decode was about to take it.
          out_valid_nxt = 1'b0;
          if (redirect_ok) begin
            pc_nxt     = redirect_pc;
            halted_nxt = 1'b0;
            state_nxt  = RUN;
          end else begin
            fault_nxt  = 1'b1;
            halted_nxt = 1'b1;
            state_nxt  = FAULT;
          end
        end else if (state == RUN) begin
          if (accept) begin
            ce            = 1'b1;
            out_valid_nxt = 1'b1;
            out_pc_nxt    = pc;
            out_inst_nxt  = data;
            count_nxt     = fetch_count + 32'd1;
            // The PC parks on the BREAK word so a debugger sees where fetch stopped.
            if (data == BREAK_WORD) begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end else begin
              pc_nxt = pc + 32'd4;
            end
          end
        end else if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
        end
      end

      default: ;  // FAULT is sticky until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_inst    <= 32'h0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      out_valid   <= out_valid_nxt;
      out_pc      <= out_pc_nxt;
      out_inst    <= out_inst_nxt;
      halted      <= halted_nxt;
      fault       <= fault_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule
